reel_compositor: RTL and testbench

REEL_COMPOSITOR -- requirements
Module: reel_compositor

---
 rtl/reel_compositor.sv | 171 +++++++++++++++++
 tb/tb_reel_compositor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/reel_compositor.sv
// Slot-machine reel compositor: double-buffered reel positions committed on frame
// boundaries, plus a registered pixel mux of frame, reel sprites and background.

module reel_lane #(
  parameter int CORDW = 16,
  parameter int COLRW = 12,
  parameter int X_LO  = 64,
  parameter int X_W   = 128
) (
  input  logic signed [CORDW-1:0] sx,
  input  logic        [COLRW-1:0] colr,
  input  logic                    inv,
  output logic                    in_x,
  output logic        [COLRW-1:0] colr_out
);
  localparam logic signed [CORDW-1:0] LO = CORDW'(X_LO);
  localparam logic signed [CORDW-1:0] HI = CORDW'(X_LO + X_W);

  // A negative sx never lands in a window, even if the bounds wrapped.
  assign in_x     = !sx[CORDW-1] && (sx >= LO) && (sx < HI);
  assign colr_out = inv ? ~colr : colr;
endmodule

module reel_compositor #(
  parameter int NREELS       = 3,
  parameter int CORDW        = 16,
  parameter int CHANW        = 4,
  parameter int REEL_X0      = 64,
  parameter int REEL_W       = 128,
  parameter int REEL_PITCH   = 192,
  parameter int WIN_Y0       = 128,
  parameter int WIN_Y1       = 352,
  parameter int PAYLINE_Y    = 239,
  parameter int REEL_Y_RST   = 176,
  parameter int BLINK_FRAMES = 16,
  parameter int FRAME_COLR   = 'h333,
  parameter int BG_COLR      = 'hFFF
) (
  input  logic                      clk_pix,
  input  logic                      rst_pix_n,
  input  logic signed [CORDW-1:0]   sx,
  input  logic signed [CORDW-1:0]   sy,
  input  logic                      de,
  input  logic                      hsync,
  input  logic                      vsync,
  input  logic                      frame,
  input  logic                      upd_valid,
  output logic                      upd_ready,
  input  logic [NREELS*CORDW-1:0]   upd_y,
  input  logic [NREELS-1:0]         upd_win,
  output logic [NREELS*CORDW-1:0]   spry,
  output logic [NREELS-1:0]         win_act,
  input  logic [NREELS*3*CHANW-1:0] spr_colr,
  input  logic [NREELS-1:0]         drawing_spr,
  output logic                      commit,
  output logic [CHANW-1:0]          vga_r,
  output logic [CHANW-1:0]          vga_g,
  output logic [CHANW-1:0]          vga_b,
  output logic                      vga_hs,
  output logic                      vga_vs
);
  localparam int COLRW = 3 * CHANW;
  localparam int FCW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [0:0] EMPTY   = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  localparam logic        [CORDW-1:0] Y_RST   = CORDW'(REEL_Y_RST);
  localparam logic signed [CORDW-1:0] WY0     = CORDW'(WIN_Y0);
  localparam logic signed [CORDW-1:0] WY1     = CORDW'(WIN_Y1);
  localparam logic signed [CORDW-1:0] PAY_Y   = CORDW'(PAYLINE_Y);
  localparam logic        [COLRW-1:0] FRAME_C = COLRW'(FRAME_COLR);
  localparam logic        [COLRW-1:0] BG_C    = COLRW'(BG_COLR);
  localparam logic        [FCW-1:0]   FC_LAST = FCW'(BLINK_FRAMES - 1);

  logic [0:0]               state;
  logic [NREELS*CORDW-1:0]  shadow_y;
  logic [NREELS-1:0]        shadow_win;
  logic [FCW-1:0]           fcnt;
  logic                     blink;

  assign upd_ready = (state == EMPTY);

  // Shadow takes the request; live registers only move on a frame pulse so a
  // frame never mixes old and new reel positions.
  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      state      <= EMPTY;
      shadow_y   <= '0;
      shadow_win <= '0;
      spry       <= {NREELS{Y_RST}};
      win_act    <= '0;
      commit     <= 1'b0;
    end else begin
      commit <= 1'b0;
      case (state)
        EMPTY: if (upd_valid) begin
          shadow_y   <= upd_y;
          shadow_win <= upd_win;
          state      <= PENDING;
        end
        default: if (frame) begin
          spry    <= shadow_y;
          win_act <= shadow_win;
          commit  <= 1'b1;
          state   <= EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      fcnt  <= '0;
      blink <= 1'b0;
    end else if (frame) begin
      if (fcnt == FC_LAST) begin
        fcnt  <= '0;
        blink <= ~blink;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  logic [NREELS-1:0]             in_x;
  logic [NREELS-1:0][COLRW-1:0]  lane_colr;

  for (genvar i = 0; i < NREELS; i++) begin : g_lane
    reel_lane #(
      .CORDW (CORDW),
      .COLRW (COLRW),
      .X_LO  (REEL_X0 + i * REEL_PITCH),
      .X_W   (REEL_W)
    ) u_lane (
      .sx       (sx),
      .colr     (spr_colr[i*COLRW +: COLRW]),
      .inv      (win_act[i] & blink),
      .in_x     (in_x[i]),
      .colr_out (lane_colr[i])
    );
  end

  logic in_row;
  logic drawing_frame;
  logic [COLRW-1:0] pix;

  assign in_row        = !sy[CORDW-1] && (sy >= WY0) && (sy < WY1);
  assign drawing_frame = (sy != PAY_Y) && (!in_row || !(|in_x));

  // Walk from the top reel down so the lowest opaque index wins.
  always_comb begin
    pix = BG_C;
    for (int i = NREELS - 1; i >= 0; i--)
      if (drawing_spr[i]) pix = lane_colr[i];
    if (drawing_frame) pix = FRAME_C;
    if (!de)           pix = '0;
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_pix_n) begin
      {vga_r, vga_g, vga_b} <= '0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      {vga_r, vga_g, vga_b} <= pix;
      vga_hs <= hsync;
      vga_vs <= vsync;
    end
  end
endmodule

// File: tb/tb_reel_compositor.sv
// Directed bench for reel_compositor: pixel vector table plus update/blink/reset sequences.

module tb_reel_compositor;
  localparam int NR = 3;
  localparam int CW = 16;

  logic clk_pix = 1'b0;
  logic rst_pix_n;
  logic signed [CW-1:0] sx, sy;
  logic de, hsync, vsync, frame, upd_valid, upd_ready, commit;
  logic [NR*CW-1:0] upd_y, spry;
  logic [NR-1:0] upd_win, win_act, drawing_spr;
  logic [NR*12-1:0] spr_colr;
  logic [3:0] vga_r, vga_g, vga_b;
  logic vga_hs, vga_vs;

  always #5 clk_pix = ~clk_pix;

  reel_compositor #(.BLINK_FRAMES(2)) dut (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de),
    .hsync(hsync), .vsync(vsync), .frame(frame), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_y(upd_y), .upd_win(upd_win), .spry(spry),
    .win_act(win_act), .spr_colr(spr_colr), .drawing_spr(drawing_spr),
    .commit(commit), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs)
  );

  typedef struct {
    logic signed [CW-1:0] sx, sy;
    logic de, hs, vs;
    logic [NR-1:0] dspr;
    logic [35:0] colr;
    logic [11:0] exp;
  } vec_t;

  vec_t vq[$];
  int ntests = 0;
  int nfail  = 0;

  localparam logic [NR*CW-1:0] Y_RST = {3{16'd176}};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pix);
    @(negedge clk_pix);
  endtask

  task automatic addv(input int x, input int y, input logic d, input logic h, input logic v,
                      input logic [2:0] ds, input logic [35:0] c, input logic [11:0] e);
    vec_t t;
    t.sx = CW'(x); t.sy = CW'(y); t.de = d; t.hs = h; t.vs = v;
    t.dspr = ds; t.colr = c; t.exp = e;
    vq.push_back(t);
  endtask

  task automatic set_pix(input int x, input int y, input logic [2:0] ds, input logic [35:0] c);
    sx = CW'(x); sy = CW'(y); de = 1'b1; drawing_spr = ds; spr_colr = c;
  endtask

  task automatic do_reset();
    rst_pix_n = 1'b0;
    step();
    step();
    rst_pix_n = 1'b1;
  endtask

  initial begin
    rst_pix_n = 1'b0; sx = '0; sy = '0; de = 1'b0; hsync = 1'b1; vsync = 1'b1;
    frame = 1'b0; upd_valid = 1'b0; upd_y = '0; upd_win = '0;
    spr_colr = '0; drawing_spr = '0;

    // sx, sy, de, hs, vs, drawing_spr, {c2,c1,c0}, expected colour
    addv(10,  200, 1, 1, 1, 3'b000, 36'h0,           12'h333); // left of reel 0
    addv(100, 239, 1, 0, 1, 3'b000, 36'h0,           12'hFFF); // payline row, inside window
    addv(100, 200, 0, 1, 0, 3'b001, 36'h000_000_ABC, 12'h000); // blanking
    addv(100, 200, 1, 0, 0, 3'b001, 36'h000_000_ABC, 12'hABC); // reel 0 sprite
    addv(300, 200, 1, 1, 1, 3'b110, 36'h222_111_000, 12'h111); // lowest opaque wins
    addv(200, 200, 1, 1, 1, 3'b111, 36'h333_222_111, 12'h333); // gap between reels
    addv(100, 127, 1, 1, 1, 3'b000, 36'h0,           12'h333); // just above window
    addv(100, 128, 1, 1, 1, 3'b000, 36'h0,           12'hFFF); // first window row
    addv(100, 351, 1, 1, 1, 3'b000, 36'h0,           12'hFFF); // last window row
    addv(100, 352, 1, 1, 1, 3'b000, 36'h0,           12'h333); // first row below
    addv(64,  200, 1, 1, 1, 3'b000, 36'h0,           12'hFFF); // left edge inclusive
    addv(191, 200, 1, 1, 1, 3'b000, 36'h0,           12'hFFF); // right edge
    addv(192, 200, 1, 1, 1, 3'b000, 36'h0,           12'h333); // right edge exclusive
    addv(-5,  200, 1, 1, 1, 3'b001, 36'h000_000_ABC, 12'h333); // negative sx
    addv(100, -1,  1, 1, 1, 3'b001, 36'h000_000_ABC, 12'h333); // negative sy
    addv(639, 200, 1, 1, 1, 3'b100, 36'h456_000_000, 12'h333); // right of reel 2 [448,576)
    addv(500, 200, 1, 1, 1, 3'b100, 36'h456_000_000, 12'h456); // reel 2 sprite

    // Reset state
    do_reset();
    chk("rst_spry", spry, Y_RST);
    chk("rst_ready", upd_ready, 1);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("rst_sync", {vga_hs, vga_vs}, 2'b11);
    chk("rst_commit", commit, 0);
    chk("rst_win", win_act, 0);

    // Pixel table (one cycle latency, syncs delayed identically)
    foreach (vq[k]) begin
      sx = vq[k].sx; sy = vq[k].sy; de = vq[k].de; hsync = vq[k].hs; vsync = vq[k].vs;
      drawing_spr = vq[k].dspr; spr_colr = vq[k].colr;
      step();
      chk($sformatf("pix%0d_rgb", k), {vga_r, vga_g, vga_b}, vq[k].exp);
      chk($sformatf("pix%0d_sync", k), {vga_hs, vga_vs}, {vq[k].hs, vq[k].vs});
    end
    hsync = 1'b1; vsync = 1'b1;

    // Update mid-frame, held until frame; second request while pending is ignored
    upd_valid = 1'b1; upd_y = {16'd100, 16'd150, 16'd200}; upd_win = 3'b000;
    step();
    upd_valid = 1'b0;
    chk("upd_ready_low", upd_ready, 0);
    chk("upd_spry_hold", spry, Y_RST);
    upd_valid = 1'b1; upd_y = {16'd9, 16'd9, 16'd9};
    step();
    step();
    upd_valid = 1'b0;
    chk("upd_spry_hold2", spry, Y_RST);
    chk("upd_no_commit", commit, 0);
    frame = 1'b1;
    step();
    frame = 1'b0;
    chk("upd_commit", commit, 1);
    chk("upd_spry_new", spry, {16'd100, 16'd150, 16'd200});
    chk("upd_ready_hi", upd_ready, 1);
    step();
    chk("upd_commit_pulse", commit, 0);

    // Accept and frame collide: load only, commit on the next frame
    upd_valid = 1'b1; frame = 1'b1; upd_y = {16'd3, 16'd2, 16'd1}; upd_win = 3'b010;
    step();
    upd_valid = 1'b0; frame = 1'b0;
    chk("col_no_commit", commit, 0);
    chk("col_ready_low", upd_ready, 0);
    chk("col_spry_old", spry, {16'd100, 16'd150, 16'd200});
    step();
    frame = 1'b1;
    step();
    frame = 1'b0;
    chk("col_commit", commit, 1);
    chk("col_spry_new", spry, {16'd3, 16'd2, 16'd1});
    chk("col_win", win_act, 3'b010);

    // Blink from a clean reset; pixel inputs stay fixed on reel 1
    do_reset();
    set_pix(300, 200, 3'b010, 36'h000_0F0_000);
    upd_valid = 1'b1; upd_y = Y_RST; upd_win = 3'b010;
    step();
    upd_valid = 1'b0;
    chk("blk_f0", {vga_r, vga_g, vga_b}, 12'h0F0);
    for (int f = 1; f <= 4; f++) begin
      frame = 1'b1;
      step();
      frame = 1'b0;
      step();
      chk($sformatf("blk_f%0d", f), {vga_r, vga_g, vga_b},
          ((f / 2) % 2 == 1) ? 12'hF0F : 12'h0F0);
    end
    chk("blk_win", win_act, 3'b010);

    // Reset while pending discards the shadow
    upd_valid = 1'b1; upd_y = {16'd7, 16'd7, 16'd7}; upd_win = 3'b111;
    step();
    upd_valid = 1'b0;
    chk("rp_pending", upd_ready, 0);
    rst_pix_n = 1'b0;
    step();
    rst_pix_n = 1'b1;
    chk("rp_ready", upd_ready, 1);
    frame = 1'b1;
    step();
    frame = 1'b0;
    chk("rp_no_commit", commit, 0);
    chk("rp_spry", spry, Y_RST);
    chk("rp_win", win_act, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
